// File: rtl/dac_sample_feeder.sv
// Sample FIFO plus rate pacer feeding an MCP4725 DAC interface.
// A sample stays outstanding until the DAC echo registers report it back.
module dac_sample_feeder #(
  parameter  int DEPTH = 8,
  parameter  int DIV_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       mode_cfg,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             run,
  input  logic             flush,
  output logic [11:0]      dac_data,
  output logic [1:0]       dac_mode,
  output logic             dac_enable,
  input  logic [11:0]      dac_data_reg,
  input  logic [1:0]       dac_mode_reg,
  output logic [AW:0]      fifo_count,
  output logic             busy,
  output logic             underrun,
  output logic             late,
  input  logic             clear_flags
);

  typedef enum logic {IDLE, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [11:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0] pace_q, pace_d;
  logic [11:0]      data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic             und_q, und_d;
  logic             late_q, late_d;
  logic             tick, push, pop, match;
  logic             und_set, late_set;

  assign s_ready    = (cnt_q != DEPTH[AW:0]);
  assign push       = s_valid && s_ready && !flush;
  assign fifo_count = cnt_q;
  assign dac_data   = data_q;
  assign dac_mode   = mode_q;
  assign dac_enable = (state_q == COMMIT);
  assign busy       = (state_q == COMMIT);
  assign underrun   = und_q;
  assign late       = late_q;
  assign match      = (dac_data_reg == data_q) && (dac_mode_reg == mode_q);

  // A rate_div lowered below the count wraps the pacer through 2^DIV_W.
  always_comb begin
    tick   = run && (pace_q == rate_div);
    pace_d = pace_q + DIV_W'(1);
    if (!run || tick) pace_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mode_d   = mode_q;
    pop      = 1'b0;
    und_set  = 1'b0;
    late_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (cnt_q == '0 || flush) begin
            und_set = 1'b1;
          end else begin
            pop     = 1'b1;
            data_d  = mem_q[rd_q];
            mode_d  = mode_cfg;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        late_set = tick;
        if (match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush)             cnt_d = '0;
    else if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    und_d  = und_set  || (und_q  && !clear_flags);
    late_d = late_set || (late_q && !clear_flags);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pace_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      und_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pace_q  <= pace_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      und_q   <= und_d;
      late_q  <= late_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder with a delayed-echo DAC model.
// Accepted pushes queue up; each dac_enable rise must present the queue head.
module tb_dac_sample_feeder;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic             clk = 0;
  logic             rst_n = 0;
  logic [11:0]      s_data = '0;
  logic             s_valid = 0;
  logic             s_ready;
  logic [1:0]       mode_cfg = '0;
  logic [DIV_W-1:0] rate_div = '0;
  logic             run = 0;
  logic             flush = 0;
  logic [11:0]      dac_data;
  logic [1:0]       dac_mode;
  logic             dac_enable;
  logic [11:0]      echo_d;
  logic [1:0]       echo_m;
  logic [3:0]       fifo_count;
  logic             busy, underrun, late;
  logic             clear_flags = 0;

  dac_sample_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mode_cfg(mode_cfg), .rate_div(rate_div), .run(run), .flush(flush),
    .dac_data(dac_data), .dac_mode(dac_mode), .dac_enable(dac_enable),
    .dac_data_reg(echo_d), .dac_mode_reg(echo_m),
    .fifo_count(fifo_count), .busy(busy), .underrun(underrun),
    .late(late), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 3;
  int dly = 0;
  logic        set_echo = 0;
  logic [11:0] set_val = '0;
  logic [11:0] exp_q[$];
  int          rise_q[$];
  int          w_q[$];
  logic        prev_en = 0, prev_busy = 0;
  int          width = 0;

  always @(posedge clk) cyc++;

  // DAC interface model: commits a differing sample lat cycles after enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_d <= '0; echo_m <= '0; dly = 0;
    end else if (set_echo) begin
      echo_d <= set_val; echo_m <= '0; dly = 0;
    end else if (dac_enable && (dac_data != echo_d || dac_mode != echo_m)) begin
      if (dly >= lat - 1) begin
        echo_d <= dac_data; echo_m <= dac_mode; dly = 0;
      end else dly++;
    end else dly = 0;
  end

  // Reference FIFO contents.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (flush) exp_q.delete();
    else if (s_valid && s_ready) exp_q.push_back(s_data);
  end

  // Monitor: every new issue must be the oldest accepted sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 0; prev_busy = 0; width = 0;
    end else begin
      if (dac_enable && !prev_en) begin
        rise_q.push_back(cyc);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL issue: got data %h with nothing queued", dac_data);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (dac_data !== e || dac_mode !== mode_cfg) begin
            n_err++;
            $display("FAIL issue: got %h/%0d expected %h/%0d",
                     dac_data, dac_mode, e, mode_cfg);
          end
        end
      end
      if (busy) width++;
      else if (prev_busy) begin w_q.push_back(width); width = 0; end
      prev_en = dac_enable;
      prev_busy = busy;
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic [11:0] d);
    int g = 0;
    s_valid = 1; s_data = d;
    while (!s_ready && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) check("push_timeout", 1, 0);
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic wait_drain(string nm);
    int g = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 0) && g < 5000) begin
      @(negedge clk); g++;
    end
    if (g >= 5000) check(nm, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rise(string nm);
    int n0 = rise_q.size();
    int g = 0;
    while (rise_q.size() == n0 && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) check(nm, 1, 0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1; @(negedge clk); clear_flags = 0;
  endtask

  initial begin
    int nr;
    repeat (2) @(negedge clk);
    check("rst_enable", dac_enable, 0);
    check("rst_count", fifo_count, 0);
    check("rst_flags", {underrun, late}, 0);
    rst_n = 1;
    @(negedge clk);

    // Pacing at 10 cycles, commit 3 cycles after enable.
    lat = 3; mode_cfg = 2'd1;
    push(12'h123); push(12'hABC); push(12'h7FF);
    rise_q.delete(); w_q.delete();
    rate_div = 9; run = 1;
    begin
      int g = 0;
      while (w_q.size() < 3 && g < 200) begin @(negedge clk); g++; end
    end
    run = 0;
    check("pace_issues", rise_q.size(), 3);
    check("pace_gap1", rise_q[1] - rise_q[0], 10);
    check("pace_gap2", rise_q[2] - rise_q[1], 10);
    check("pace_w0", w_q[0], 4);
    check("pace_w2", w_q[2], 4);
    check("pace_flags", {underrun, late}, 0);

    // Fill to full and hold a ninth sample back.
    for (int i = 0; i < 8; i++) push(12'($urandom));
    check("full_count", fifo_count, 8);
    check("full_ready", s_ready, 0);
    s_valid = 1; s_data = 12'($urandom);
    repeat (3) @(negedge clk);
    check("full_held", fifo_count, 8);
    rate_div = 0; run = 1;
    begin
      int g = 0;
      while (!s_ready && g < 200) begin @(negedge clk); g++; end
    end
    @(negedge clk);
    s_valid = 0;
    wait_drain("drain_timeout");
    run = 0;
    check("drain_ready", s_ready, 1);
    pulse_clear();

    // Underrun on an empty FIFO.
    rate_div = 4; run = 1;
    repeat (7) @(negedge clk);
    run = 0;
    check("underrun_set", underrun, 1);
    check("underrun_nolate", late, 0);
    pulse_clear();
    check("clear_flags", {underrun, late}, 0);

    // Slow commit: ticks arrive while busy.
    lat = 12;
    push(12'h0F0); push(12'h00F);
    rise_q.delete();
    run = 1;
    wait_drain("late_timeout");
    run = 0;
    check("late_set", late, 1);
    check("late_issues", rise_q.size(), 2);
    pulse_clear();
    check("late_clear", {underrun, late}, 0);

    // Echo already holds the value: single-cycle retire.
    mode_cfg = 0; lat = 3;
    set_val = 12'h555; set_echo = 1; @(negedge clk); set_echo = 0;
    push(12'h555); push(12'h555);
    w_q.delete();
    rate_div = 3; run = 1;
    wait_drain("repeat_timeout");
    run = 0;
    check("repeat_n", w_q.size(), 2);
    check("repeat_w0", w_q[0], 1);
    check("repeat_w1", w_q[1], 1);
    pulse_clear();

    // Flush during COMMIT together with a push.
    lat = 12; mode_cfg = 2'd2;
    for (int i = 0; i < 6; i++) push(12'h100 + 12'(i));
    w_q.delete();
    rate_div = 3; run = 1;
    wait_rise("flush_rise");
    check("flush_pre", fifo_count, 5);
    flush = 1; s_valid = 1; s_data = 12'hFFF;
    @(negedge clk);
    flush = 0; s_valid = 0;
    check("flush_count", fifo_count, 0);
    check("flush_busy", busy, 1);
    nr = rise_q.size();
    repeat (40) @(negedge clk);
    check("flush_commit", busy, 0);
    check("flush_width", w_q[0], 13);
    check("flush_nopop", rise_q.size(), nr);
    check("flush_underrun", underrun, 1);
    push(12'h321);
    wait_drain("flush_timeout");
    run = 0;
    check("flush_repop", rise_q.size(), nr + 1);
    pulse_clear();

    // Randomized traffic.
    for (int r = 0; r < 3; r++) begin
      rate_div = 16'($urandom_range(0, 6));
      lat = $urandom_range(1, 6);
      mode_cfg = 2'($urandom);
      run = 1;
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(12'($urandom));
      end
      wait_drain("rand_timeout");
      run = 0;
      check("rand_left", exp_q.size(), 0);
    end
    pulse_clear();

    // Asynchronous reset in the middle of a commit.
    lat = 20;
    push(12'hA5A);
    rate_div = 1; run = 1;
    wait_rise("reset_rise");
    #2 rst_n = 0;
    #1;
    check("arst_enable", dac_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_data", {dac_data, dac_mode}, 0);
    check("arst_count", fifo_count, 0);
    run = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("post_busy", busy, 0);
    check("post_count", fifo_count, 0);
    check("post_ready", s_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Upstream stage for the MCP4725 DAC interface.
- Buffers 12-bit samples from a producer through a valid/ready FIFO and paces them out at a programmable sample rate.
- Drives the DAC interface's data_i/mode_i/enable inputs and watches its data_reg/mode_reg echo outputs to learn when each sample has been committed over I2C.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
DIV_W, 16, width of the sample-rate divider

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
s_data  in  12  producer sample
s_valid  in  1  producer sample valid
s_ready  out  1  FIFO can accept a sample (~full)
mode_cfg  in  2  power-down mode sent with every sample
rate_div  in  DIV_W  sample period minus 1, in clk cycles
run  in  1  enable pacing
flush  in  1  one-cycle pulse; empties FIFO
dac_data  out  12  to DAC interface data_i
dac_mode  out  2  to DAC interface mode_i
dac_enable  out  1  to DAC interface enable
dac_data_reg  in  12  from DAC interface data_reg
dac_mode_reg  in  2  from DAC interface mode_reg
fifo_count  out  log2(DEPTH)+1  current occupancy
busy  out  1  sample issued, not yet committed
underrun  out  1  sticky: tick found FIFO empty
late  out  1  sticky: tick arrived while still busy
clear_flags  in  1  one-cycle pulse; clears underrun and late

Behaviour:
- Reset values (asynchronous, rst_n=0): dac_data=0, dac_mode=0, dac_enable=0, busy=0, underrun=0, late=0, fifo_count=0, FIFO pointers=0, pacer=0, state=IDLE.
- FIFO push: occurs when s_valid & s_ready. s_ready = (fifo_count != DEPTH), combinational from count only. A pop in the same cycle does not raise s_ready while the FIFO is full.
- Pointers: wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Pacer:
  - run=0: counter held at 0, no ticks.
  - run=1: counter increments each cycle. tick=1 when counter==rate_div, and the counter returns to 0 on the same edge.
  - rate_div=0: tick every cycle.
  - Change of rate_div mid-count: takes effect from the next compare. If counter > new rate_div, the counter wraps through 2^DIV_W.
- State machine, 2 states:
  - IDLE, on tick with FIFO non-empty: pop the head. Next edge: dac_data=head, dac_mode=mode_cfg, dac_enable=1, busy=1, go to COMMIT.
  - IDLE, on tick with FIFO empty: underrun<=1; outputs hold; stay in IDLE.
  - COMMIT: dac_enable held at 1. Each cycle, compare (dac_data_reg==dac_data && dac_mode_reg==dac_mode). On match: next edge dac_enable=0, busy=0, go to IDLE. Minimum COMMIT duration is 1 cycle.
  - COMMIT, tick arrives: late<=1; the tick is discarded, with no pop and no underrun. The sample continues waiting; never dropped, never aborted.
- Repeated sample: if the popped sample equals the current echo, the DAC interface starts no transaction. The compare matches on the first COMMIT cycle, so the sample is retired in 1 cycle.
- flush: same cycle sets pointers and count to 0. Flush wins over a simultaneous push (push is lost, s_ready still reported) and over a simultaneous pop.
  - flush in COMMIT: the in-flight sample still completes normally.
  - flush in IDLE with a tick in the same cycle: treated as empty, so underrun<=1.
- clear_flags vs. flag set in the same cycle: the set wins.
- run deasserted in COMMIT: the current sample completes; no further pops.
- Latency: tick-to-dac_enable is 1 cycle. Push to earliest pop is 1 cycle; a sample pushed at edge N is poppable by a tick sampled at edge N+1.

Test Plan:
- Reset sequence: rst_n low mid-COMMIT with dac_enable=1 -> all outputs 0 asynchronously; after release, state IDLE and fifo_count=0.
- Pacing: rate_div=9, run=1, push 0x123,0xABC,0x7FF with echo model committing 3 cycles after enable -> dac_enable rises every 10 cycles; dac_data sequence 0x123,0xABC,0x7FF; busy for 4 cycles each; no flags.
- Full/backpressure: DEPTH=8, run=0, push 9 samples -> s_ready=0 after the 8th push, fifo_count=8, 9th held. Set run=1 with rate_div=0 -> samples drain in order, s_ready returns high.
- Underrun and late: empty FIFO, run=1, rate_div=4 -> underrun=1 at the first tick. Separately, an echo model committing after 12 cycles with rate_div=4 -> late=1 and no sample lost. clear_flags -> both 0.
- Repeated value: push 0x555 twice with mode_cfg=0, with the echo already at 0x555 -> each retires after 1 COMMIT cycle; dac_enable is a 1-cycle pulse.
- Flush: 5 entries queued, flush coincident with a push and while COMMIT is active -> fifo_count=0 next cycle; the in-flight sample still commits; no further pops until a new push.
